cplx_delay_line: RTL and testbench

CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

---
 rtl/cplx_dly_pkg.sv | 12 +
 rtl/cplx_dly_ram.sv | 35 +++
 rtl/cplx_delay_line.sv | 85 ++++++++
 tb/tb_cplx_delay_line.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cplx_dly_pkg.sv
// Shared constants and the pointer-width helper for the complex delay line.
package cplx_dly_pkg;

    localparam int CPLX_W       = 32;
    localparam int CPLX_DLY_MAX = 1024;

    // Address width of the (depth-1)-entry circular buffer, never below 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth - 1 > 1) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/cplx_dly_ram.sv
// Circular-buffer storage: untagged data words plus a clearable valid tag per entry.
module cplx_dly_ram
    import cplx_dly_pkg::*;
#(
    parameter int W       = CPLX_W,
    parameter int ENTRIES = 1,
    parameter int AW      = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [2*W:0]  wdata,
    output logic [2*W:0]  rdata
);

    // A single entry is padded to two so that the 1-bit address indexes it exactly.
    localparam int SLOTS = (ENTRIES < 2) ? 2 : ENTRIES;

    logic [2*W-1:0]   mem [SLOTS];
    logic [SLOTS-1:0] tag;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata[2*W-1:0];
    end

    // Only the tags are cleared; stale words behind a zero tag can never surface as valid.
    always_ff @(posedge clk) begin
        if (clr)     tag       <= '0;
        else if (we) tag[addr] <= wdata[2*W];
    end

    assign rdata = {tag[addr], mem[addr]};

endmodule

// File: rtl/cplx_delay_line.sv
// Complex-sample delay line of DEPTH advances with a travelling valid tag.
// Optional macro CPLX_DLY_FLUSH_EN adds a flush input equivalent to rst.
module cplx_delay_line
    import cplx_dly_pkg::*;
#(
    parameter int W     = CPLX_W,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CPLX_DLY_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                en,
    input  logic                in_valid,
    input  logic signed [W-1:0] c_re,
    input  logic signed [W-1:0] c_img,
    output logic                out_valid,
    output logic signed [W-1:0] c1_re,
    output logic signed [W-1:0] c1_img,
    output logic                primed
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          clr;
    logic          adv;
    logic [2*W:0]  src;
    logic [CW-1:0] fill_p0;

`ifdef CPLX_DLY_FLUSH_EN
    assign clr = rst | flush;
`else
    assign clr = rst;
`endif
    // A clearing edge swallows any simultaneous advance, including its input sample.
    assign adv = en & ~clr;

    generate
        if (DEPTH == 1) begin : g_reg
            assign src = {in_valid, c_re, c_img};
        end else begin : g_ram
            localparam int PW = ptr_w(DEPTH);
            localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);

            logic [PW-1:0] ptr_p0;

            always_ff @(posedge clk) begin
                if (clr)      ptr_p0 <= '0;
                else if (adv) ptr_p0 <= (ptr_p0 == PTR_LAST) ? '0 : ptr_p0 + 1'b1;
            end

            cplx_dly_ram #(
                .W       (W),
                .ENTRIES (DEPTH - 1),
                .AW      (PW)
            ) u_ram (
                .clk   (clk),
                .clr   (clr),
                .we    (adv),
                .addr  (ptr_p0),
                .wdata ({in_valid, c_re, c_img}),
                .rdata (src)
            );
        end
    endgenerate

    // Output stage: the slot read at ptr lands here on the same advance that overwrites it.
    always_ff @(posedge clk) begin
        if (clr)      {out_valid, c1_re, c1_img} <= '0;
        else if (adv) {out_valid, c1_re, c1_img} <= src;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            fill_p0 <= '0;
            primed  <= 1'b0;
        end else if (adv && fill_p0 != FULL) begin
            fill_p0 <= fill_p0 + 1'b1;
            primed  <= (fill_p0 + 1'b1 == FULL);
        end
    end

endmodule

// File: tb/tb_cplx_delay_line.sv
// Scoreboard bench: five delay lines of different depths share one directed stimulus stream.
module tb_cplx_delay_line;

    localparam int W = 16;
    localparam int N = 5;

    function automatic int dep(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 5;
            3:       return 8;
            default: return 19;
        endcase
    endfunction

    typedef struct packed {
        logic         v;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } samp_t;

    typedef struct packed {
        logic [N-1:0]        v;
        logic [N-1:0]        chk;
        logic [N-1:0]        pr;
        logic [N-1:0][W-1:0] re;
        logic [N-1:0][W-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic [W-1:0] c_re = '0;
    logic [W-1:0] c_img = '0;
`ifdef CPLX_DLY_FLUSH_EN
    logic flush = 1'b0;
`endif

    logic [N-1:0]        ov;
    logic [N-1:0]        pr;
    logic [N-1:0][W-1:0] ore;
    logic [N-1:0][W-1:0] oim;

    int    n_vec = 0;
    int    n_err = 0;
    int    n_adv = 0;
    samp_t hist[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cplx_delay_line #(.W(W), .DEPTH(dep(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
`ifdef CPLX_DLY_FLUSH_EN
            .flush     (flush),
`endif
            .en        (en),
            .in_valid  (in_valid),
            .c_re      (c_re),
            .c_img     (c_img),
            .out_valid (ov[g]),
            .c1_re     (ore[g]),
            .c1_img    (oim[g]),
            .primed    (pr[g])
        );
    end

    task automatic cmp(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s depth=%0d got %h want %h at %0t", nm, d, act, want, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int g = 0; g < N; g++) begin
                    cmp("out_valid", dep(g), W'(ov[g]), W'(e.v[g]));
                    cmp("primed", dep(g), W'(pr[g]), W'(e.pr[g]));
                    if (e.chk[g]) begin
                        cmp("c1_re", dep(g), ore[g], e.re[g]);
                        cmp("c1_img", dep(g), oim[g], e.im[g]);
                    end
                end
            end
        end
    end

    // Drive one edge's inputs and queue what every depth must show after that edge.
    task automatic step(input logic r, input logic e, input logic v, input int re, input int im,
                        input logic fl = 1'b0);
        exp_t  x;
        samp_t s;
        int    d;
        @(negedge clk);
        rst      = r;
        en       = e;
        in_valid = v;
        c_re     = W'(re);
        c_img    = W'(im);
`ifdef CPLX_DLY_FLUSH_EN
        flush    = fl;
`endif
        if (r || fl) begin
            hist.delete();
            n_adv = 0;
        end else if (e) begin
            s.v  = v;
            s.re = W'(re);
            s.im = W'(im);
            hist.push_back(s);
            n_adv++;
        end
        x = '0;
        for (int g = 0; g < N; g++) begin
            d = dep(g);
            x.pr[g] = (n_adv >= d);
            if (n_adv >= d) begin
                s        = hist[n_adv - d];
                x.v[g]   = s.v;
                x.re[g]  = s.re;
                x.im[g]  = s.im;
                x.chk[g] = 1'b1;
            end else begin
                // Before the line fills, outputs are the reset zeros or stale untagged words.
                x.chk[g] = (n_adv == 0);
            end
        end
        exp_q.push_back(x);
    endtask

    initial begin
        // Reset with en high must still clear everything.
        step(1, 1, 1, 'h55, 'h66);
        step(1, 1, 1, 'h77, 'h88);
        // Single sample 0x1/0x2: the depth-1 line shows it right after this edge.
        step(0, 1, 1, 1, 2);
        step(0, 0, 0, 0, 0);

        // Continuous ramp from a fresh reset: depth 19 shows k after edge k+18.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 26; k++) step(0, 1, 1, k, -k);

        // Alternating enable: outputs move only on enabled edges.
        for (int i = 0; i < 14; i++) step(0, (i % 2) == 0, 1, 100 + i, 200 + i);

        // Valid pattern 1,0,0,1,1 repeated, carried with distinct data.
        for (int i = 0; i < 15; i++) step(0, 1, (i % 5 == 0) || (i % 5 >= 3), 300 + i, -300 - i);

`ifdef CPLX_DLY_FLUSH_EN
        // Flush together with en: the input is dropped and state matches post-reset.
        step(0, 1, 1, 'h3a, 'h3b, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 400 + i, 500 + i);
`endif

        // Mid-stream reset after six valid samples, then a long run with mixed valids.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 600 + i, 700 + i);
        step(1, 1, 1, 'h999, 'h998);
        for (int i = 0; i < 26; i++) step(0, 1, (i % 3) != 1, 800 + i, -800 - i);

        // Idle edges: everything holds.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 'hbad, 'hbad);

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
